// File: rtl/bits2bytes_stream.sv
// bits2bytes_stream: LSB-first bit-to-byte packer; clk/rst, in_valid/in_ready/in_bits[IN_W]/in_last in, out_valid/out_ready/out_bytes[N_BYTES][8]/out_last/out_nbytes out
module bits2bytes_stream #(
  parameter int N_BYTES = 4,
  parameter int IN_W = 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [IN_W-1:0]                    in_bits,
  input  logic                               in_last,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [N_BYTES-1:0][7:0]            out_bytes,
  output logic                               out_last,
  output logic [$clog2(N_BYTES+1)-1:0]       out_nbytes
);
  localparam int W = N_BYTES * 8;
  localparam int BEATS = W / IN_W;
  localparam int CW = $clog2(BEATS + 1);
  localparam int NW = $clog2(N_BYTES + 1);
  if (N_BYTES < 1 || !(IN_W == 1 || IN_W == 2 || IN_W == 4 || IN_W == 8)) begin : g_bad
    $fatal(1, "bits2bytes_stream: N_BYTES must be >= 1 and IN_W one of 1, 2, 4, 8");
  end
  typedef enum logic {FILL, HOLD} state_t;
  state_t state;
  logic [CW-1:0] cnt, idx;
  logic [W-1:0] acc, beat;
  logic fire, done;
  assign in_ready = state == FILL || out_ready;
  assign out_valid = state == HOLD;
  assign out_bytes = acc;
  always_comb begin
    idx = state == HOLD ? '0 : cnt;
    fire = in_valid && in_ready;
    done = fire && (idx == CW'(BEATS - 1) || in_last);
    beat = W'(in_bits) << (32'(idx) * 32'(IN_W));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FILL;
      cnt <= '0;
      acc <= '0;
      out_last <= 1'b0;
      out_nbytes <= '0;
    end else if (fire) begin
      acc <= (state == HOLD ? '0 : acc) | beat;
      cnt <= done ? '0 : idx + CW'(1);
      state <= done ? HOLD : FILL;
      if (done) begin
        out_last <= in_last;
        out_nbytes <= in_last ? NW'(((32'(idx) + 32'd1) * 32'(IN_W) + 32'd7) / 32'd8) : NW'(N_BYTES);
      end
    end else if (state == HOLD && out_ready) begin
      acc <= '0;
      cnt <= '0;
      state <= FILL;
    end
  end
endmodule

// File: tb/tb_bits2bytes_stream.sv
// tb_bits2bytes_stream: randomized and directed checks of bits2bytes_stream against a bit-queue reference model
module tb_bits2bytes_stream;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0, in_bits = 1'b0, in_last = 1'b0, out_ready = 1'b1;
  logic in_ready, out_valid, out_last;
  logic [3:0][7:0] out_bytes;
  logic [2:0] out_nbytes;
  logic v8 = 1'b0, l8 = 1'b0, r8 = 1'b1;
  logic [7:0] b8 = '0;
  logic rdy8, val8, last8, nb8;
  logic [0:0][7:0] ob8;
  int n_chk = 0, n_fail = 0;
  bit cur[$];
  logic [31:0] eq_w[$];
  logic eq_l[$];
  int eq_n[$];

  bits2bytes_stream #(.N_BYTES(4), .IN_W(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_bits(in_bits),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_bytes(out_bytes),
    .out_last(out_last), .out_nbytes(out_nbytes)
  );

  bits2bytes_stream #(.N_BYTES(1), .IN_W(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(v8), .in_ready(rdy8), .in_bits(b8),
    .in_last(l8), .out_valid(val8), .out_ready(r8), .out_bytes(ob8),
    .out_last(last8), .out_nbytes(nb8)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input logic v, input logic b, input logic l, input logic r);
    logic [31:0] w;
    bit pend;
    in_valid = v;
    in_bits = b;
    in_last = l;
    out_ready = r;
    @(negedge clk);
    pend = eq_w.size() != 0;
    chk("out_valid", 32'(out_valid), 32'(pend));
    chk("in_ready", 32'(in_ready), 32'(!pend || r));
    if (pend) begin
      chk("out_bytes", out_bytes, eq_w[0]);
      chk("out_last", 32'(out_last), 32'(eq_l[0]));
      chk("out_nbytes", 32'(out_nbytes), 32'(eq_n[0]));
      if (r) begin
        void'(eq_w.pop_front());
        void'(eq_l.pop_front());
        void'(eq_n.pop_front());
      end
    end
    if (v && (!pend || r)) begin
      cur.push_back(b);
      if (cur.size() == 32 || l) begin
        w = '0;
        foreach (cur[k]) w[k] = cur[k];
        eq_w.push_back(w);
        eq_l.push_back(l);
        eq_n.push_back((cur.size() + 7) / 8);
        cur.delete();
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [31:0] w, input int nb, input bit last);
    for (int k = 0; k < nb; k++) step(1'b1, w[k], last && k == nb - 1, 1'b1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_ready", 32'(in_ready), 1);
    chk("rst_bytes", out_bytes, 0);
    chk("rst_last", 32'(out_last), 0);
    chk("rst_nbytes", 32'(out_nbytes), 0);
    @(posedge clk);
    #1;
    feed(32'h89ABCDEF, 32, 0);
    chk("word_b0", 32'(out_bytes[0]), 32'hEF);
    chk("word_b3", 32'(out_bytes[3]), 32'h89);
    for (int k = 0; k < 10; k++) step(1'b1, 1'($urandom), 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    for (int k = 1; k < 32; k++) step(1'b1, 1'(32'h13579BDF >> k), 1'b0, 1'b1);
    feed(32'h00000000, 32, 0);
    feed(32'hFFFFFFFF, 32, 0);
    feed(32'h00010203, 32, 0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    feed(32'h00000ABC, 12, 1);
    chk("part_nbytes", 32'(out_nbytes), 2);
    chk("part_bytes", out_bytes, 32'h00000ABC);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    feed($urandom, 20, 0);
    rst = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    in_valid = 1'b0;
    cur.delete();
    eq_w.delete();
    eq_l.delete();
    eq_n.delete();
    @(negedge clk);
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_bytes", out_bytes, 0);
    chk("mid_rst_ready", 32'(in_ready), 1);
    @(posedge clk);
    #1;
    feed(32'h12345678, 32, 0);
    chk("after_rst", out_bytes, 32'h12345678);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 800; k++)
      step(1'($urandom % 4 != 0), 1'($urandom), 1'($urandom % 20 == 0), 1'($urandom % 3 != 0));
    repeat (2) step(1'b0, 1'b0, 1'b0, 1'b1);
    b8 = 8'h5A;
    v8 = 1'b1;
    @(negedge clk);
    chk("w8_ready", 32'(rdy8), 1);
    chk("w8_idle", 32'(val8), 0);
    @(posedge clk);
    #1 b8 = 8'hA5;
    @(negedge clk);
    chk("w8_v0", 32'(val8), 1);
    chk("w8_b0", 32'(ob8[0]), 32'h5A);
    @(posedge clk);
    #1 b8 = 8'h3C;
    @(negedge clk);
    chk("w8_v1", 32'(val8), 1);
    chk("w8_b1", 32'(ob8[0]), 32'hA5);
    chk("w8_ready1", 32'(rdy8), 1);
    @(posedge clk);
    #1 v8 = 1'b0;
    @(negedge clk);
    chk("w8_v2", 32'(val8), 1);
    chk("w8_b2", 32'(ob8[0]), 32'h3C);
    chk("w8_last", 32'(last8), 0);
    chk("w8_nb", 32'(nb8), 1);
    @(posedge clk);
    @(negedge clk);
    chk("w8_done", 32'(val8), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
